// File: rtl/pc_gen_if.sv
// Decoupled fetch-address bus from the PC generator to instruction fetch.
// Transfer happens on a cycle where valid && ready; data must stay stable while valid && !ready.
interface pc_gen_if #(
   parameter int ADDR_WIDTH = 64
) ();
   logic                  valid;
   logic                  ready;
   logic [ADDR_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator feeding instruction fetch: sequential PCs, redirect/flush, halt/drain.
// Optional misaligned-redirect trap is enabled by defining PCGEN_MISALIGN_TRAP_EN.
module pc_gen #(
   parameter int                    ADDR_WIDTH  = 64,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(64'h8000_0000),
   parameter int unsigned           FETCH_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pc_gen_if.master              pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   input  logic                  halt_req,
   output logic                  flush,
   output logic                  halted,
`ifdef PCGEN_MISALIGN_TRAP_EN
   output logic                  trap,
   output logic [ADDR_WIDTH-1:0] trap_pc,
`endif
   output logic [2:0]            state_dbg_o
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_RUN    = 3'd1,
      S_DRAIN  = 3'd2,
      S_HALTED = 3'd3
`ifdef PCGEN_MISALIGN_TRAP_EN
      , S_TRAP = 3'd4
`endif
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] INCR       = ADDR_WIDTH'(FETCH_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(INCR - ADDR_WIDTH'(1));

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  issuing;
   logic                  valid_w;
   logic                  handshake;
   logic                  in_halt;
`ifdef PCGEN_MISALIGN_TRAP_EN
   logic [ADDR_WIDTH-1:0] trap_pc_q, trap_pc_d;
   logic                  misaligned;
   assign misaligned = |(redirect_target & ~ALIGN_MASK);
   assign in_halt    = (state_q == S_HALTED) || (state_q == S_TRAP);
`else
   assign in_halt    = (state_q == S_HALTED);
`endif

   // valid depends only on state and redirect, never on ready.
   assign issuing   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign valid_w   = issuing && !redirect_valid && !rst;
   assign handshake = valid_w && pc.ready;

   assign pc.valid    = valid_w;
   assign pc.data     = pc_q;
   assign flush       = redirect_valid && !rst;
   assign halted      = in_halt && !rst;
   assign state_dbg_o = state_q;
`ifdef PCGEN_MISALIGN_TRAP_EN
   assign trap        = (state_q == S_TRAP) && !rst;
   assign trap_pc     = trap_pc_q;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PCGEN_MISALIGN_TRAP_EN
      trap_pc_d = trap_pc_q;
`endif
      if (handshake) begin
         pc_d = pc_q + INCR;
      end
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN: begin
            if (halt_req) begin
               state_d = handshake ? S_HALTED : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (handshake) begin
               state_d = S_HALTED;
            end
         end
         default: state_d = state_q;
      endcase
      // A redirect overrides halt and any handshake in the same cycle.
      if (redirect_valid) begin
`ifdef PCGEN_MISALIGN_TRAP_EN
         if (misaligned) begin
            state_d   = S_TRAP;
            pc_d      = pc_q;
            trap_pc_d = redirect_target;
         end else begin
            state_d = S_RUN;
            pc_d    = redirect_target;
         end
`else
         state_d = S_RUN;
         pc_d    = redirect_target & ALIGN_MASK;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
`ifdef PCGEN_MISALIGN_TRAP_EN
         trap_pc_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
`ifdef PCGEN_MISALIGN_TRAP_EN
         trap_pc_q <= trap_pc_d;
`endif
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: per-cycle vector table plus a handshake scoreboard.
module tb_pc_gen;
   localparam int AW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_target = '0;
   logic          halt_req = 1'b0;
   logic          flush, halted, flush2, halted2;
   logic [2:0]    state_dbg, state_dbg2;
`ifdef PCGEN_MISALIGN_TRAP_EN
   logic          trap, trap2;
   logic [AW-1:0] trap_pc, trap_pc2;
`endif

   int checks   = 0;
   int failures = 0;
   logic [AW-1:0] exp_q[$];

   pc_gen_if #(.ADDR_WIDTH(AW)) pc_bus ();
   pc_gen_if #(.ADDR_WIDTH(AW)) wrap_bus ();

   pc_gen #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .pc(pc_bus),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt_req(halt_req), .flush(flush), .halted(halted),
`ifdef PCGEN_MISALIGN_TRAP_EN
      .trap(trap), .trap_pc(trap_pc),
`endif
      .state_dbg_o(state_dbg)
   );

   pc_gen #(.ADDR_WIDTH(AW), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .pc(wrap_bus),
      .redirect_valid(1'b0), .redirect_target('0),
      .halt_req(1'b0), .flush(flush2), .halted(halted2),
`ifdef PCGEN_MISALIGN_TRAP_EN
      .trap(trap2), .trap_pc(trap_pc2),
`endif
      .state_dbg_o(state_dbg2)
   );

   // clock / reset
   always #5 clk = ~clk;
   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic          rst, rdy, rv;
      logic [AW-1:0] tgt;
      logic          halt;
      logic          ev, ef, eh;
      logic [AW-1:0] ed;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] tgt,
                      input logic halt, input logic ev, input logic ef, input logic eh,
                      input logic [AW-1:0] ed);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rv = rv; v.tgt = tgt; v.halt = halt;
      v.ev = ev; v.ef = ef; v.eh = eh; v.ed = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every handshake must match the next expected address
   always @(negedge clk) begin
      if (pc_bus.valid === 1'b1 && pc_bus.ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: handshake of 0x%0h with nothing expected", pc_bus.data);
         end else begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            if (pc_bus.data !== e) begin
               failures++;
               $display("FAIL sb_data: got 0x%0h expected 0x%0h", pc_bus.data, e);
            end
         end
      end
   end

   initial begin
      pc_bus.ready   = 1'b1;
      wrap_bus.ready = 1'b1;
      //   rst rdy rv  target            halt ev ef eh data
      add(1, 1, 0, 64'h0,           0, 0, 0, 0, 64'h0);           // 0 reset
      add(1, 1, 1, 64'h40,          1, 0, 0, 0, 64'h0);           // 1 redirect during reset
      add(0, 1, 0, 64'h0,           0, 0, 0, 0, 64'h0);           // 2 BOOT
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0000);   // 3
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0004);   // 4
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 64'h0,        0, 1, 0, 0, 64'h8000_0008);   // 5-9 backpressure
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0008);   // 10
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_000C);   // 11
      add(0, 1, 1, 64'h8000_1000,   0, 0, 1, 0, 64'h0);           // 12 redirect beats ready
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_1000);   // 13
      add(0, 0, 1, 64'h8000_0020,   0, 0, 1, 0, 64'h0);           // 14
      add(0, 0, 0, 64'h0,           1, 1, 0, 0, 64'h8000_0020);   // 15 halt -> DRAIN
      add(0, 0, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0020);   // 16 DRAIN holds
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0020);   // 17 drain handshake
      add(0, 1, 0, 64'h0,           0, 0, 0, 1, 64'h0);           // 18 HALTED
      add(0, 1, 0, 64'h0,           1, 0, 0, 1, 64'h0);           // 19 halt ignored
      add(0, 1, 1, 64'h100,         0, 0, 1, 1, 64'h0);           // 20 resume
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h100);         // 21
      add(0, 1, 0, 64'h0,           1, 1, 0, 0, 64'h104);         // 22 halt with handshake
      add(0, 1, 0, 64'h0,           0, 0, 0, 1, 64'h0);           // 23
      add(0, 1, 1, 64'h300,         0, 0, 1, 1, 64'h0);           // 24 back-to-back redirect
      add(0, 1, 1, 64'h200,         1, 0, 1, 0, 64'h0);           // 25 last wins, halt dropped
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h200);         // 26
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h204);         // 27
      add(0, 1, 1, 64'h8000_1002,   0, 0, 1, 0, 64'h0);           // 28 misaligned redirect
`ifdef PCGEN_MISALIGN_TRAP_EN
      add(0, 1, 0, 64'h0,           0, 0, 0, 1, 64'h0);           // 29 TRAP
      add(0, 1, 1, 64'h8000_2000,   0, 0, 1, 1, 64'h0);           // 30
`else
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_1000);   // 29 low bits cleared
      add(0, 1, 1, 64'h8000_2000,   0, 0, 1, 0, 64'h0);           // 30
`endif
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_2000);   // 31
      add(1, 1, 1, 64'h40,          1, 0, 0, 0, 64'h0);           // 32 reset mid-operation
      add(0, 1, 0, 64'h0,           0, 0, 0, 0, 64'h0);           // 33 BOOT
      add(0, 1, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0000);   // 34
      add(0, 0, 0, 64'h0,           0, 1, 0, 0, 64'h8000_0004);   // 35

      // driver: apply row just after posedge, check at the following negedge
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         rst             = vecs[i].rst;
         pc_bus.ready    = vecs[i].rdy;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].tgt;
         halt_req        = vecs[i].halt;
         if (vecs[i].ev && vecs[i].rdy) exp_q.push_back(vecs[i].ed);
         @(negedge clk);
         check($sformatf("valid[%0d]", i), AW'(pc_bus.valid), AW'(vecs[i].ev));
         check($sformatf("flush[%0d]", i), AW'(flush), AW'(vecs[i].ef));
         check($sformatf("halted[%0d]", i), AW'(halted), AW'(vecs[i].eh));
         if (vecs[i].ev) check($sformatf("data[%0d]", i), pc_bus.data, vecs[i].ed);
         if (i == 3) check("wrap_first", wrap_bus.data, 64'hFFFF_FFFF_FFFF_FFFC);
         if (i == 4) check("wrap_zero", wrap_bus.data, 64'h0);
`ifdef PCGEN_MISALIGN_TRAP_EN
         if (i == 28 || i == 31) check($sformatf("trap[%0d]", i), AW'(trap), AW'(0));
         if (i == 29) begin
            check("trap_set", AW'(trap), AW'(1));
            check("trap_pc", trap_pc, 64'h8000_1002);
         end
`endif
      end

      @(posedge clk);
      #1;
      pc_bus.ready   = 1'b0;
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
      repeat (3) @(negedge clk);
      check("sb_drained", AW'(exp_q.size()), AW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
